// File: rtl/qei_gen_if.sv
// Command/status bundle between a quadrature-generator controller and qei_gen.
interface qei_gen_if #(
    parameter int per_w = 16
);
    logic             clr;
    logic             en;
    logic [per_w-1:0] period_i;
    logic             dir_i;
    logic             A_o;
    logic             B_o;
    logic             I_o;
    logic             step_o;
    logic [31:0]      pos_o;

    modport master (
        output clr, en, period_i, dir_i,
        input  A_o, B_o, I_o, step_o, pos_o
    );

    modport slave (
        input  clr, en, period_i, dir_i,
        output A_o, B_o, I_o, step_o, pos_o
    );
endinterface

// File: rtl/qei_gen.sv
// Quadrature A/B (+ optional index) generator with programmable edge period and emitted-position tracking.
// Index output and revolution counter are compiled in only when QEI_GEN_INDEX_EN is defined.
//
// state | meaning
// 00    | A=0 B=0
// 01    | A=0 B=1 (first step forward from 00)
// 11    | A=1 B=1
// 10    | A=1 B=0 (first step reverse from 00)
module qei_gen #(
    parameter int per_w = 16,
    parameter int cpr   = 2048
) (
    input  logic      clk,
    input  logic      rst,
    qei_gen_if.slave  bus
);
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    generate
        if (cpr < 4) begin : g_cpr_chk
            $error("qei_gen: cpr must be >= 4");
        end
    endgenerate

    logic [1:0]       phase_q, phase_d;
    logic [per_w-1:0] timer_q, timer_d;
    logic [per_w-1:0] period_q, period_d;
    logic             dir_q, dir_d;
    logic [31:0]      pos_q, pos_d;
    logic             step_q, step_d;
    logic             step_now;

    // Period and direction are latched together so a mid-dwell change only affects the following dwell.
    assign step_now = bus.en && !bus.clr && (period_q != '0) && (timer_q == period_q - 1'b1);

    always_comb begin
        phase_d  = phase_q;
        timer_d  = timer_q;
        period_d = period_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        step_d   = 1'b0;
        if (bus.clr) begin
            phase_d  = PH_00;
            timer_d  = '0;
            period_d = '0;
            pos_d    = '0;
        end else if (bus.en) begin
            if (period_q == '0) begin
                period_d = bus.period_i;
                dir_d    = bus.dir_i;
                timer_d  = '0;
            end else if (step_now) begin
                timer_d  = '0;
                period_d = bus.period_i;
                dir_d    = bus.dir_i;
                step_d   = 1'b1;
                pos_d    = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                case (phase_q)
                    PH_00:   phase_d = dir_q ? PH_01 : PH_10;
                    PH_01:   phase_d = dir_q ? PH_11 : PH_00;
                    PH_11:   phase_d = dir_q ? PH_10 : PH_01;
                    default: phase_d = dir_q ? PH_00 : PH_11;
                endcase
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_00;
            timer_q  <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            pos_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            step_q   <= step_d;
        end
    end

    assign bus.A_o    = phase_q[1];
    assign bus.B_o    = phase_q[0];
    assign bus.step_o = step_q;
    assign bus.pos_o  = pos_q;

`ifdef QEI_GEN_INDEX_EN
    localparam int         REV_W   = $clog2(cpr);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(cpr - 1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             idx_q, idx_d;

    always_comb begin
        rev_d = rev_q;
        if (bus.clr) begin
            rev_d = '0;
        end else if (step_now) begin
            if (dir_q) rev_d = (rev_q == REV_MAX) ? '0 : rev_q + 1'b1;
            else       rev_d = (rev_q == '0) ? REV_MAX : rev_q - 1'b1;
        end
        idx_d = (rev_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_q <= '0;
            idx_q <= 1'b0;
        end else begin
            rev_q <= rev_d;
            idx_q <= idx_d;
        end
    end

    assign bus.I_o = idx_q;
`else
    assign bus.I_o = 1'b0;
`endif
endmodule
